fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Owns the program counter and sequences instruction fetch for the 5-stage pipeline.
- Each cycle, selects the next PC from:
  - branch redirect (EX/MEM, PCSrc)
  - jump redirect (ID)
  - hazard stall
  - sequential PC+4
- Runs a single-outstanding-request handshake to instruction memory.
- Presents fetched instructions to the IF/ID register through a one-entry buffer, with flush/valid control.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- ADDR_W, 32, PC / instruction address width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- br_taken  in  1  branch resolved taken (PCSrc)
- br_target  in  ADDR_W  branch target address
- jump  in  1  jump decoded in ID
- jabs  in  ADDR_W  absolute jump target
- stall  in  1  hazard unit: hold IF/ID, do not consume if_instr
- imem_req  out  1  fetch request valid
- imem_addr  out  ADDR_W  fetch address, stable while imem_req && !imem_gnt
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid (≥1 cycle after gnt)
- imem_rdata  in  32  instruction word
- if_valid  out  1  if_instr/if_pc valid for IF/ID
- if_instr  out  32  fetched instruction
- if_pc  out  ADDR_W  address of if_instr
- if_pc_plus_4  out  ADDR_W  if_pc + 4
- flush_ifid  out  1  one-cycle pulse: squash IF/ID contents

Behaviour:
- **Reset (async, rst_n=0):**
  - pc=RESET_PC; state=S_BOOT.
  - imem_req=0, if_valid=0, flush_ifid=0.
  - if_instr, if_pc, if_pc_plus_4 = 0; drop flag=0; buffer empty.
- **States:**
  - S_BOOT: one cycle after reset release, then S_ISSUE.
  - S_ISSUE: imem_req=1, imem_addr=pc. On imem_gnt, go to S_WAIT.
  - S_WAIT: imem_req=0.
    - On imem_rvalid with drop=0: capture rdata into the buffer, pc += 4 (mod 2^ADDR_W, wrap silently).
    - On imem_rvalid with drop=1: discard the data, clear drop.
    - Next state is S_ISSUE, unless the buffer is full and stall=1, in which case S_HOLD.
  - S_HOLD: no request; wait until stall=0, then S_ISSUE.
- **Next-PC priority (evaluated every cycle, registered):** br_taken > jump > sequential.
  - Redirect loads pc with br_target or jabs.
  - Redirect asserts flush_ifid for exactly one cycle and invalidates the buffer.
  - If state=S_WAIT at redirect, set drop=1: the in-flight response is discarded, not presented.
  - If state=S_ISSUE without gnt at redirect, imem_addr switches to the new pc the next cycle.
  - If gnt coincides with the redirect, drop=1.
- **Redirect overrides stall:** br_taken or jump with stall=1 still redirects and flushes.
- **Buffer (1 entry):**
  - if_valid = buffer full.
  - Entry is consumed on the cycle if_valid && !stall.
  - A new entry may be written the same cycle it is consumed.
  - No new request is issued while the buffer is full and stall=1, so at most one instruction is ever pending.
- **Latency:**
  - Reset release → first imem_req: 1 cycle.
  - rvalid → if_valid: 1 cycle.
  - Redirect → imem_req at target: ≤2 cycles, or after the dropped response returns.
- **Sequential PC alignment:** pc[1:0] is forced to 0 on every load.
- **Reset mid-transaction:** outstanding response is ignored. Memory must tolerate an abandoned request.

Optional Feature:
- Macro: FETCH_SEQ_PERF_EN.
- When defined, adds three outputs:
  - perf_redirects (32): count of redirect events.
  - perf_stall_cycles (32): cycles with if_valid && stall.
  - perf_dropped (32): count of discarded responses.
- All three counters saturate at all-ones and reset to 0.
- When undefined: the ports and counters are absent; core behaviour is identical.

Decomposition:
- Shared package `pipe_pkg`:
  - state enum (S_BOOT, S_ISSUE, S_WAIT, S_HOLD)
  - RESET_PC default
  - PC_INC = 4
  - next-PC select encoding (SEL_SEQ, SEL_BR, SEL_JMP)
- Sub-module `next_pc_sel`: combinational priority mux with inputs br_taken, jump, stall and sequential PC. It replaces the existing two-level PC mux.
- FSM, buffer and drop logic stay in the top module.

Test Plan:
- Reset release, imem grants immediately, rvalid 1 cycle later, rdata 0x20080005 → if_valid=1, if_pc=0x0, if_pc_plus_4=0x4; next imem_addr=0x4.
- stall=1 for 3 cycles with buffer full → imem_req=0 during the stall; if_instr/if_pc unchanged; issue resumes the cycle after stall=0.
- br_taken=1, br_target=0x100 while in S_WAIT → flush_ifid pulses 1 cycle; pending rvalid discarded (if_valid stays 0); next imem_addr=0x100.
- br_taken=1 (0x200) and jump=1 (0x300) in the same cycle → pc=0x200, single flush pulse.
- pc=0xFFFFFFFC sequential fetch → next imem_addr=0x00000000.
- rst_n low while in S_WAIT, rvalid arrives during reset → outputs at reset values; first post-reset imem_addr=RESET_PC; with FETCH_SEQ_PERF_EN, counters read 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the instruction fetch sequencer and its next-PC mux.
package pipe_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned PC_INC           = 32'd4;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_BR  = 2'd1,
        SEL_JMP = 2'd2
    } pc_sel_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC priority mux: branch redirect over jump over sequential advance; stall holds the PC.
module next_pc_sel import pipe_pkg::*; #(
    parameter int ADDR_W = 32
) (
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jabs,
    input  logic              stall,
    input  logic [ADDR_W-1:0] pc,
    output pc_sel_e           sel,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] raw_s;

    // Priority select; every loaded address is word aligned
    always_comb begin
        sel   = SEL_SEQ;
        raw_s = pc;
        if (br_taken) begin
            sel   = SEL_BR;
            raw_s = br_target;
        end else if (jump) begin
            sel   = SEL_JMP;
            raw_s = jabs;
        end else if (stall) begin
            raw_s = pc;
        end else begin
            raw_s = pc + ADDR_W'(PC_INC);
        end
        next_pc = {raw_s[ADDR_W-1:2], 2'b00};
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter owner and single-outstanding instruction fetch with a one-entry IF/ID buffer.
// Optional performance counters are built when FETCH_SEQ_PERF_EN is defined.
module fetch_sequencer import pipe_pkg::*; #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jabs,
    input  logic              stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_plus_4,
    output logic              flush_ifid
`ifdef FETCH_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_redirects,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_dropped
`endif
);

    fetch_state_e      state_r, state_nxt_s;
    logic              drop_r, drop_nxt_s;
    logic [ADDR_W-1:0] pc_r, pc_nxt_s;
    pc_sel_e           sel_s;
    logic              redirect_s, consume_s, rsp_s, capture_s, discard_s, hold_pc_s, buf_nxt_s;

    next_pc_sel #(.ADDR_W(ADDR_W)) u_next_pc_sel (
        .br_taken  (br_taken),
        .br_target (br_target),
        .jump      (jump),
        .jabs      (jabs),
        .stall     (hold_pc_s),
        .pc        (pc_r),
        .sel       (sel_s),
        .next_pc   (pc_nxt_s)
    );

    // Response classification, next state, drop flag and buffer occupancy.
    // A response that finds the buffer still full and stalled is discarded and refetched later,
    // so no instruction is ever lost and at most one is pending.
    always_comb begin
        redirect_s  = br_taken || jump;
        consume_s   = if_valid && !stall;
        rsp_s       = (state_r == S_WAIT) && imem_rvalid;
        capture_s   = rsp_s && !drop_r && !redirect_s && (!if_valid || !stall);
        discard_s   = rsp_s && !capture_s;
        hold_pc_s   = !capture_s;
        state_nxt_s = state_r;
        drop_nxt_s  = drop_r;
        case (state_r)
            S_BOOT: begin
                state_nxt_s = S_ISSUE;
            end
            S_ISSUE: begin
                if (imem_gnt) begin
                    state_nxt_s = S_WAIT;
                    drop_nxt_s  = redirect_s;
                end else if (if_valid && stall && !redirect_s) begin
                    state_nxt_s = S_HOLD;
                end else begin
                    state_nxt_s = S_ISSUE;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    drop_nxt_s = 1'b0;
                    if (stall && !drop_r && !redirect_s) begin
                        state_nxt_s = S_HOLD;
                    end else begin
                        state_nxt_s = S_ISSUE;
                    end
                end else begin
                    drop_nxt_s  = drop_r || redirect_s;
                    state_nxt_s = S_WAIT;
                end
            end
            S_HOLD: begin
                if (redirect_s || !stall) begin
                    state_nxt_s = S_ISSUE;
                end else begin
                    state_nxt_s = S_HOLD;
                end
            end
            default: begin
                state_nxt_s = S_BOOT;
                drop_nxt_s  = 1'b0;
            end
        endcase
        if (redirect_s) begin
            buf_nxt_s = 1'b0;
        end else if (capture_s) begin
            buf_nxt_s = 1'b1;
        end else if (consume_s) begin
            buf_nxt_s = 1'b0;
        end else begin
            buf_nxt_s = if_valid;
        end
    end

    // PC, FSM and IF/ID-facing registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_BOOT;
            drop_r       <= 1'b0;
            pc_r         <= RESET_PC;
            imem_req     <= 1'b0;
            if_valid     <= 1'b0;
            flush_ifid   <= 1'b0;
            if_instr     <= 32'h0000_0000;
            if_pc        <= {ADDR_W{1'b0}};
            if_pc_plus_4 <= {ADDR_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            drop_r     <= drop_nxt_s;
            pc_r       <= pc_nxt_s;
            imem_req   <= (state_nxt_s == S_ISSUE);
            if_valid   <= buf_nxt_s;
            flush_ifid <= (sel_s != SEL_SEQ);
            if (capture_s) begin
                if_instr     <= imem_rdata;
                if_pc        <= pc_r;
                if_pc_plus_4 <= pc_r + ADDR_W'(PC_INC);
            end
        end
    end

    assign imem_addr = pc_r;

`ifdef FETCH_SEQ_PERF_EN
    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_redirects    <= 32'h0000_0000;
            perf_stall_cycles <= 32'h0000_0000;
            perf_dropped      <= 32'h0000_0000;
        end else begin
            if (redirect_s) begin
                perf_redirects <= sat_inc(perf_redirects);
            end
            if (if_valid && stall) begin
                perf_stall_cycles <= sat_inc(perf_stall_cycles);
            end
            if (discard_s) begin
                perf_dropped <= sat_inc(perf_dropped);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; the bench plays instruction memory.
module tb_fetch_sequencer;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic              jump;
    logic [ADDR_W-1:0] jabs;
    logic              stall;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [31:0]       imem_rdata;
    logic              if_valid;
    logic [31:0]       if_instr;
    logic [ADDR_W-1:0] if_pc;
    logic [ADDR_W-1:0] if_pc_plus_4;
    logic              flush_ifid;
`ifdef FETCH_SEQ_PERF_EN
    logic [31:0]       perf_redirects;
    logic [31:0]       perf_stall_cycles;
    logic [31:0]       perf_dropped;
`endif

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    fetch_sequencer #(.ADDR_W(ADDR_W), .RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .jump         (jump),
        .jabs         (jabs),
        .stall        (stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .if_pc_plus_4 (if_pc_plus_4),
        .flush_ifid   (flush_ifid)
`ifdef FETCH_SEQ_PERF_EN
        ,
        .perf_redirects    (perf_redirects),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_dropped      (perf_dropped)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        sb_q.push_back(e);
    endtask

    task automatic chk_fetch(input string tag);
        exp_t e;
        chk({tag, "_valid"}, 32'(if_valid), 32'd1);
        chk({tag, "_sb_pending"}, 32'(sb_q.size()), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({tag, "_instr"}, if_instr, e.instr);
            chk({tag, "_pc"}, if_pc, e.pc);
            chk({tag, "_pc4"}, if_pc_plus_4, e.pc + 32'd4);
        end
    endtask

    initial begin
        rst_n = 1'b0; br_taken = 1'b0; br_target = 32'h0; jump = 1'b0; jabs = 32'h0;
        stall = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        step(); step();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_flush", 32'(flush_ifid), 32'd0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_pc4", if_pc_plus_4, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);

        // Boot and first fetch: immediate grant, data one cycle later
        rst_n = 1'b1; step();
        chk("boot_req", 32'(imem_req), 32'd1);
        chk("boot_addr", imem_addr, 32'h0);
        imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
        chk("wait_req", 32'(imem_req), 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'h2008_0005; push_exp(32'h2008_0005, 32'h0);
        step(); imem_rvalid = 1'b0;
        chk_fetch("first");
        chk("first_next_addr", imem_addr, 32'h4);
        chk("first_next_req", 32'(imem_req), 32'd1);

        // Three stall cycles with the buffer full
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_req", 32'(imem_req), 32'd0);
            chk("stall_valid", 32'(if_valid), 32'd1);
            chk("stall_instr", if_instr, 32'h2008_0005);
            chk("stall_pc", if_pc, 32'h0);
        end
        stall = 1'b0; step();
        chk("resume_req", 32'(imem_req), 32'd1);
        chk("resume_addr", imem_addr, 32'h4);
        chk("resume_consumed", 32'(if_valid), 32'd0);

        // Branch while waiting: response is dropped
        imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
        br_taken = 1'b1; br_target = 32'h100; step(); br_taken = 1'b0;
        chk("br_flush", 32'(flush_ifid), 32'd1);
        chk("br_req", 32'(imem_req), 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; step(); imem_rvalid = 1'b0;
        chk("br_flush_pulse", 32'(flush_ifid), 32'd0);
        chk("br_dropped", 32'(if_valid), 32'd0);
        chk("br_req_after", 32'(imem_req), 32'd1);
        chk("br_addr", imem_addr, 32'h100);

        // Branch beats jump in the same cycle
        br_taken = 1'b1; br_target = 32'h200; jump = 1'b1; jabs = 32'h300; step();
        br_taken = 1'b0; jump = 1'b0;
        chk("prio_flush", 32'(flush_ifid), 32'd1);
        chk("prio_addr", imem_addr, 32'h200);
        step();
        chk("prio_single_pulse", 32'(flush_ifid), 32'd0);
        chk("prio_addr_hold", imem_addr, 32'h200);

        // Misaligned jump to the top of the address space, then sequential wrap
        jump = 1'b1; jabs = 32'hFFFF_FFFE; step(); jump = 1'b0;
        chk("jmp_flush", 32'(flush_ifid), 32'd1);
        chk("jmp_aligned_addr", imem_addr, 32'hFFFF_FFFC);
        imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h8C22_0000; push_exp(32'h8C22_0000, 32'hFFFF_FFFC);
        step(); imem_rvalid = 1'b0;
        chk_fetch("wrap");
        chk("wrap_addr", imem_addr, 32'h0);

        // Jump coincident with grant: that response is dropped
        imem_gnt = 1'b1; jump = 1'b1; jabs = 32'h40; step(); imem_gnt = 1'b0; jump = 1'b0;
        chk("gntjmp_flush", 32'(flush_ifid), 32'd1);
        chk("gntjmp_req", 32'(imem_req), 32'd0);
        chk("gntjmp_addr", imem_addr, 32'h40);
        imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111; step(); imem_rvalid = 1'b0;
        chk("gntjmp_dropped", 32'(if_valid), 32'd0);
        chk("gntjmp_req_after", 32'(imem_req), 32'd1);
        imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013; push_exp(32'h0000_0013, 32'h40);
        step(); imem_rvalid = 1'b0;
        chk_fetch("after_drop");
        chk("after_drop_addr", imem_addr, 32'h44);

        // Stall arrives as a request is granted: the late response is refetched
        stall = 1'b1; imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222; step(); imem_rvalid = 1'b0;
        chk("replay_hold_req", 32'(imem_req), 32'd0);
        chk("replay_keep_pc", if_pc, 32'h40);
        chk("replay_keep_instr", if_instr, 32'h0000_0013);
        stall = 1'b0; step();
        chk("replay_req", 32'(imem_req), 32'd1);
        chk("replay_addr", imem_addr, 32'h44);
`ifdef FETCH_SEQ_PERF_EN
        chk("perf_redirects", perf_redirects, 32'd4);
        chk("perf_stall_cycles", perf_stall_cycles, 32'd5);
        chk("perf_dropped", perf_dropped, 32'd3);
`endif

        // Reset while a response is outstanding
        imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
        rst_n = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333;
        step(); step(); imem_rvalid = 1'b0;
        chk("midrst_req", 32'(imem_req), 32'd0);
        chk("midrst_valid", 32'(if_valid), 32'd0);
        chk("midrst_instr", if_instr, 32'h0);
        chk("midrst_pc", if_pc, 32'h0);
        chk("midrst_addr", imem_addr, 32'h0);
`ifdef FETCH_SEQ_PERF_EN
        chk("midrst_perf_redirects", perf_redirects, 32'd0);
        chk("midrst_perf_stall", perf_stall_cycles, 32'd0);
        chk("midrst_perf_dropped", perf_dropped, 32'd0);
`endif
        rst_n = 1'b1; step();
        chk("postrst_req", 32'(imem_req), 32'd1);
        chk("postrst_addr", imem_addr, 32'h0);
        imem_rvalid = 1'b1; imem_rdata = 32'h4444_4444; step(); imem_rvalid = 1'b0;
        chk("postrst_stray_ignored", 32'(if_valid), 32'd0);
        chk("postrst_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
